// File: rtl/inst_loader_if.sv
// Host-to-loader bus: received byte handshake plus instruction RAM write port
// and CPU control/status lines. The loader is the slave; the host/bench side is
// the master.
interface inst_loader_if #(
  parameter int ADDR_W = 6
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/inst_loader.sv
// Instruction loader: parses SYNC / N / 4*N little-endian data bytes from the
// host byte stream, writes each assembled word into the instruction RAM from
// address 0 upward, and holds the CPU in reset while a program is loading.
module inst_loader #(
  parameter int         ADDR_W        = 6,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter bit         HOLD_AT_RESET = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  inst_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, COUNT, DATA, WRITE} state_t;

  // Largest legal word count, widened so 2^8 is representable.
  localparam logic [8:0] CAPACITY = 9'(1 << ADDR_W);

  state_t            state_reg;
  state_t            state_next;
  logic [7:0]        n_reg;
  logic [ADDR_W:0]   word_cnt_reg;
  logic [1:0]        byte_cnt_reg;
  logic [23:0]       asm_reg;        // lanes 0..2; lane 3 goes straight to mem_wdata
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_waddr_reg;
  logic [31:0]       mem_wdata_reg;
  logic              done_reg;
  logic              err_reg;
  logic              cpu_hold_reg;

  logic              rx_ready;
  logic              busy;
  logic              xfer;
  logic              count_bad;
  logic              last_word;

  // Next-state decode, handshake and busy; WRITE is the only cycle that refuses bytes.
  always_comb begin
    state_next = state_reg;
    rx_ready   = 1'b1;
    busy       = 1'b1;
    xfer       = 1'b0;
    count_bad  = (bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > CAPACITY);
    last_word  = ((9'(word_cnt_reg) + 9'd1) == {1'b0, n_reg});
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        xfer = bus.rx_valid;
        if (xfer && (bus.rx_data == SYNC_BYTE)) begin
          state_next = COUNT;
        end
      end
      COUNT: begin
        xfer = bus.rx_valid;
        if (xfer) begin
          state_next = count_bad ? IDLE : DATA;
        end
      end
      DATA: begin
        xfer = bus.rx_valid;
        if (xfer && (byte_cnt_reg == 2'd3)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        rx_ready   = 1'b0;
        state_next = done_reg ? IDLE : DATA;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: counters, word assembly, registered RAM write and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_reg         <= 8'd0;
      word_cnt_reg  <= '0;
      byte_cnt_reg  <= 2'd0;
      asm_reg       <= 24'd0;
      mem_we_reg    <= 1'b0;
      mem_waddr_reg <= '0;
      mem_wdata_reg <= 32'd0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      cpu_hold_reg  <= HOLD_AT_RESET;
    end else begin
      mem_we_reg <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (xfer && (bus.rx_data == SYNC_BYTE)) begin
            cpu_hold_reg <= 1'b1;
          end
        end
        COUNT: begin
          if (xfer) begin
            if (count_bad) begin
              err_reg <= 1'b1;
            end else begin
              n_reg        <= bus.rx_data;
              word_cnt_reg <= '0;
              byte_cnt_reg <= 2'd0;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            case (byte_cnt_reg)
              2'd0: asm_reg[7:0]   <= bus.rx_data;
              2'd1: asm_reg[15:8]  <= bus.rx_data;
              2'd2: asm_reg[23:16] <= bus.rx_data;
              default: begin
                // Fourth byte completes the word; present it in the WRITE cycle.
                mem_we_reg    <= 1'b1;
                mem_waddr_reg <= word_cnt_reg[ADDR_W-1:0];
                mem_wdata_reg <= {bus.rx_data, asm_reg};
                done_reg      <= last_word;
              end
            endcase
          end
        end
        WRITE: begin
          word_cnt_reg <= word_cnt_reg + 1'b1;
          if (done_reg) begin
            cpu_hold_reg <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.busy      = busy;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_waddr = mem_waddr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.cpu_hold  = cpu_hold_reg;
endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: drives byte packets (fixed and random,
// with optional gaps) and compares observed RAM writes, done/err pulses and
// cpu_hold behaviour against a packet-level reference model.
module tb_inst_loader;
  localparam int         ADDR_W = 6;
  localparam logic [7:0] SYNC   = 8'hA5;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  logic reset = 1'b1;

  inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .HOLD_AT_RESET(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Observations collected by the monitor.
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                done_q[$];
  int                err_cnt;
  int                rdy_low;
  int                seq_bad;
  logic              prev_done;

  // Expectations produced by the model.
  logic [ADDR_W-1:0] exp_a[$];
  logic [31:0]       exp_d[$];
  int                exp_done[$];
  int                exp_err;
  logic              exp_hold = 1'b1;

  // Monitor: records writes, done/err pulses and timing relationships.
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (bus.mem_we) begin
        wa_q.push_back(bus.mem_waddr);
        wd_q.push_back(bus.mem_wdata);
        if (bus.rx_ready) seq_bad++;
      end
      if (bus.done) begin
        done_q.push_back(wa_q.size());
        if (!bus.mem_we || bus.cpu_hold !== 1'b1) seq_bad++;
      end
      if (prev_done && (bus.cpu_hold !== 1'b0 || bus.busy !== 1'b0)) seq_bad++;
      if (bus.err) err_cnt++;
      if (!bus.rx_ready) rdy_low++;
      prev_done = bus.done;
    end
  end

  task automatic clear_mon();
    wa_q.delete(); wd_q.delete(); done_q.delete();
    err_cnt = 0; rdy_low = 0; seq_bad = 0;
  endtask

  // Packet-level model: scan for SYNC, read N, take 4*N bytes as LE words.
  task automatic model(input byte_q_t b);
    int i; int n; int nw;
    exp_a.delete(); exp_d.delete(); exp_done.delete(); exp_err = 0;
    i = 0;
    while (i < b.size()) begin
      if (b[i] !== SYNC) begin i++; continue; end
      exp_hold = 1'b1;
      if (i + 1 >= b.size()) break;
      n = int'(b[i+1]);
      i += 2;
      if (n == 0 || n > (1 << ADDR_W)) begin exp_err++; continue; end
      nw = 0;
      for (int k = 0; k < n; k++) begin
        if (i + 4*k + 3 < b.size()) begin
          exp_a.push_back(ADDR_W'(k));
          exp_d.push_back({b[i+4*k+3], b[i+4*k+2], b[i+4*k+1], b[i+4*k]});
          nw++;
        end
      end
      if (nw == n) begin exp_done.push_back(exp_a.size()); exp_hold = 1'b0; end
      i += 4*n;
    end
  endtask

  // Drive one byte (after an optional idle gap) and wait for it to be accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    waited = 0;
    while (bus.rx_ready !== 1'b1 && waited < 16) begin @(posedge clk); #1; waited++; end
    if (waited >= 16) begin
      n_cmp++; n_fail++;
      $display("FAIL rx_ready_timeout: rx_ready stuck at %b, required 1", bus.rx_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic play(input byte_q_t b, input int gap_max);
    foreach (b[i]) send_byte(b[i], (gap_max == 0) ? 0 : int'($urandom_range(gap_max)));
    bus.rx_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    exp_hold = 1'b1;
    n_cmp++; if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rx_ready: got %b required 1", bus.rx_ready); end
    n_cmp++; if (bus.mem_we !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: we/done/err/busy got %b%b%b%b required 0000", bus.mem_we, bus.done, bus.err, bus.busy); end
    n_cmp++; if (bus.mem_waddr !== '0 || bus.mem_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_bus: waddr %h wdata %h required 0 0", bus.mem_waddr, bus.mem_wdata); end
    n_cmp++; if (bus.cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b required 1", bus.cpu_hold); end
  endtask

  task automatic test_single_word();
    byte_q_t b = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h50, 8'h00};
    clear_mon(); model(b); play(b, 0);
    n_cmp++; if (wa_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== 32'h00500013) begin
      n_fail++; $display("FAIL single_write: %0d writes, first data %h, required 1 write of 00500013 at 0", wa_q.size(), (wd_q.size() > 0) ? wd_q[0] : 32'hx); end
    n_cmp++; if (done_q.size() != 1 || done_q[0] != 1) begin
      n_fail++; $display("FAIL single_done: %0d done pulses, required 1 with the write", done_q.size()); end
    n_cmp++; if (seq_bad != 0) begin n_fail++; $display("FAIL single_timing: %0d hold/busy/done timing errors, required 0", seq_bad); end
    n_cmp++; if (bus.cpu_hold !== exp_hold || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL single_release: hold %b busy %b, required %b 0", bus.cpu_hold, bus.busy, exp_hold); end
    $display("single_word: %0d writes, done=%0d", wa_q.size(), done_q.size());
  endtask

  task automatic test_full_stream();
    byte_q_t b = '{8'hA5, 8'h40};
    for (int k = 0; k < 256; k++) b.push_back(8'(k));
    clear_mon(); model(b); play(b, 0);
    n_cmp++; if (wa_q.size() != exp_a.size()) begin
      n_fail++; $display("FAIL full_count: got %0d writes required %0d", wa_q.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      n_cmp++; if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL full_word%0d: got %h@%0d required %h@%0d", i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]); end
    end
    n_cmp++; if (wd_q.size() != 64 || wd_q[0] !== 32'h03020100 || wd_q[63] !== 32'hFFFEFDFC) begin
      n_fail++; $display("FAIL full_ends: first/last words wrong, required 03020100 and fffefdfc"); end
    n_cmp++; if (rdy_low != 64) begin n_fail++; $display("FAIL full_ready_low: got %0d cycles required 64", rdy_low); end
    n_cmp++; if (done_q.size() != 1 || done_q[0] != 64) begin
      n_fail++; $display("FAIL full_done: %0d pulses, required 1 on write 64", done_q.size()); end
    n_cmp++; if (seq_bad != 0 || bus.cpu_hold !== exp_hold) begin
      n_fail++; $display("FAIL full_timing: %0d timing errors, hold %b required %b", seq_bad, bus.cpu_hold, exp_hold); end
    $display("full_stream: %0d writes, ready-low cycles %0d", wa_q.size(), rdy_low);
  endtask

  task automatic test_count_errors();
    byte_q_t b = '{8'hA5, 8'h00, 8'hA5, 8'h41, 8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_mon(); model(b); play(b, 1);
    n_cmp++; if (err_cnt != 2) begin n_fail++; $display("FAIL cnt_err: got %0d err cycles required 2", err_cnt); end
    n_cmp++; if (wa_q.size() != 1 || wa_q[0] !== '0 || wd_q[0] !== 32'hEFBEADDE) begin
      n_fail++; $display("FAIL cnt_write: %0d writes, required 1 of efbeadde at 0", wa_q.size()); end
    n_cmp++; if (done_q.size() != exp_done.size() || bus.cpu_hold !== exp_hold) begin
      n_fail++; $display("FAIL cnt_done: %0d done, hold %b required %0d, %b", done_q.size(), bus.cpu_hold, exp_done.size(), exp_hold); end
    $display("count_errors: err=%0d writes=%0d", err_cnt, wa_q.size());
  endtask

  task automatic test_garbage_sync();
    byte_q_t b = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h02};
    for (int k = 0; k < 8; k++) b.push_back(8'($urandom));
    clear_mon(); model(b); play(b, 2);
    n_cmp++; if (err_cnt != 0) begin n_fail++; $display("FAIL garbage_err: got %0d required 0", err_cnt); end
    n_cmp++; if (wa_q.size() != exp_a.size()) begin
      n_fail++; $display("FAIL garbage_count: got %0d required %0d", wa_q.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      n_cmp++; if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL garbage_word%0d: got %h@%0d required %h@%0d", i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]); end
    end
    $display("garbage_sync: %0d writes", wa_q.size());
  endtask

  task automatic test_reset_mid_load();
    byte_q_t b = '{8'hA5, 8'h05};
    for (int k = 0; k < 14; k++) b.push_back(8'($urandom_range(255, 1)));
    clear_mon(); model(b); play(b, 0);
    n_cmp++; if (wa_q.size() != 3 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL midrst_before: %0d writes busy %b, required 3 1", wa_q.size(), bus.busy); end
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      n_cmp++; if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL midrst_word%0d: got %h@%0d required %h@%0d", i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]); end
    end
    #2 reset = 1'b1;
    #1;
    exp_hold = 1'b1;
    n_cmp++; if (bus.mem_waddr !== '0 || bus.mem_wdata !== 32'd0 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async: waddr %h wdata %h busy %b we %b, required all 0", bus.mem_waddr, bus.mem_wdata, bus.busy, bus.mem_we); end
    n_cmp++; if (bus.cpu_hold !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_hold: hold %b done %b err %b, required 1 0 0", bus.cpu_hold, bus.done, bus.err); end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.rx_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b required 1", bus.rx_ready); end
    b = '{8'hA5, 8'h05};
    for (int k = 0; k < 20; k++) b.push_back(8'($urandom));
    clear_mon(); model(b); play(b, 1);
    n_cmp++; if (wa_q.size() != 5) begin n_fail++; $display("FAIL midrst_reload_count: got %0d required 5", wa_q.size()); end
    for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
      n_cmp++; if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL midrst_reload%0d: got %h@%0d required %h@%0d", i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]); end
    end
    n_cmp++; if (done_q.size() != 1 || bus.cpu_hold !== exp_hold) begin
      n_fail++; $display("FAIL midrst_done: %0d done hold %b, required 1 %b", done_q.size(), bus.cpu_hold, exp_hold); end
    $display("reset_mid_load: reload wrote %0d words", wa_q.size());
  endtask

  task automatic test_gapped_sync_data();
    byte_q_t b = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44};
    clear_mon(); model(b); play(b, 7);
    n_cmp++; if (wa_q.size() != 2 || wd_q[0] !== 32'hA5A5A5A5 || wd_q[1] !== 32'h44332211 || wa_q[1] !== ADDR_W'(1)) begin
      n_fail++; $display("FAIL gapped_words: %0d writes, required a5a5a5a5@0 44332211@1", wa_q.size()); end
    n_cmp++; if (done_q.size() != 1 || done_q[0] != 2 || seq_bad != 0) begin
      n_fail++; $display("FAIL gapped_done: %0d done pulses, %0d timing errors, required 1 and 0", done_q.size(), seq_bad); end
    $display("gapped_sync_data: %0d writes", wa_q.size());
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      byte_q_t b;
      logic [7:0] g;
      int n;
      b.delete();
      for (int k = 0; k < int'($urandom_range(3)); k++) begin
        g = 8'($urandom);
        if (g == SYNC) g = 8'h00;
        b.push_back(g);
      end
      n = int'($urandom_range(1 << ADDR_W, 1));
      b.push_back(SYNC); b.push_back(8'(n));
      for (int k = 0; k < 4*n; k++) b.push_back(8'($urandom));
      clear_mon(); model(b); play(b, 2);
      n_cmp++; if (wa_q.size() != exp_a.size() || err_cnt != exp_err) begin
        n_fail++; $display("FAIL rand%0d_count: %0d writes %0d err, required %0d %0d", it, wa_q.size(), err_cnt, exp_a.size(), exp_err); end
      for (int i = 0; i < exp_a.size() && i < wa_q.size(); i++) begin
        n_cmp++; if (wa_q[i] !== exp_a[i] || wd_q[i] !== exp_d[i]) begin
          n_fail++; $display("FAIL rand%0d_word%0d: got %h@%0d required %h@%0d", it, i, wd_q[i], wa_q[i], exp_d[i], exp_a[i]); end
      end
      n_cmp++; if (done_q.size() != 1 || done_q[0] != n || bus.cpu_hold !== exp_hold || seq_bad != 0) begin
        n_fail++; $display("FAIL rand%0d_done: %0d done, hold %b, %0d timing errors", it, done_q.size(), bus.cpu_hold, seq_bad); end
      $display("random[%0d]: N=%0d, %0d writes", it, n, wa_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_stream();
    test_count_errors();
    test_garbage_sync();
    test_reset_mid_load();
    test_gapped_sync_data();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction store: takes a byte stream from a host link and writes 32-bit instruction words into the instruction RAM that the fetch stage reads at word address PC[7:2].
- Holds the CPU in reset while a program is loading, then releases it.
- Sits between the host receive path (UART RX byte interface) and the instruction RAM write port / CPU reset.

Parameters:
- ADDR_W, 6, instruction RAM word-address width; capacity is 2^ADDR_W words; legal range 1..8.
- SYNC_BYTE, 8'hA5, packet start marker.
- HOLD_AT_RESET, 1, cpu_hold value after reset: 1 = CPU held until the first successful load; 0 = CPU runs the existing contents.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction RAM write enable, one-cycle pulse per word.
- mem_waddr  output  ADDR_W  RAM word address.
- mem_wdata  output  32  RAM write data.
- cpu_hold  output  1  drives CPU reset (OR'd with system reset).
- busy  output  1  high while a packet is in progress.
- done  output  1  one-cycle pulse when the last word is written.
- err  output  1  one-cycle pulse on a protocol error.

Behaviour:
- Byte transfer occurs on a rising edge with rx_valid && rx_ready. rx_data is sampled only on a transfer.
- Packet format:
  - SYNC_BYTE.
  - N (8-bit word count; legal 1..2^ADDR_W).
  - 4*N data bytes, little-endian per word: the first byte of each word goes to [7:0], the fourth to [31:24].
- States: IDLE, COUNT, DATA, WRITE.
- IDLE:
  - rx_ready=1, busy=0.
  - A byte equal to SYNC_BYTE: go to COUNT, set cpu_hold=1 and busy=1.
  - Any other byte: discarded silently, no err.
- COUNT:
  - rx_ready=1.
  - N=0 or N>2^ADDR_W: err pulse the next cycle; go to IDLE; cpu_hold keeps its current value; no writes.
  - Otherwise: latch N; clear the word counter and byte counter (2-bit); go to DATA.
- DATA:
  - rx_ready=1.
  - Each transfer shifts the byte into the word assembly register at the byte-counter lane, then the byte counter increments.
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle):
  - rx_ready=0, mem_we=1, mem_waddr=word counter, mem_wdata=assembled word. All outputs are registered.
  - Word counter increments, wrapping modulo 2^ADDR_W+1 width.
  - If word counter+1 == N: done=1 in this same cycle; cpu_hold=0 from the next cycle; go to IDLE.
  - Otherwise go to DATA.
- Latency: mem_we is asserted in the cycle after the edge that accepts the 4th byte. Peak throughput is 1 word per 5 cycles.
- Writes always start at word address 0. Addresses are written in ascending order with no gaps.
- A SYNC_BYTE arriving in DATA is treated as data; it does not resynchronise.
- The host must not send more than 4*N data bytes. Extra bytes land in IDLE and are discarded unless they equal SYNC_BYTE.
- rx_valid without rx_ready is a host-side hold. The byte must stay stable; the loader does not drop it.
- Reset, asynchronous, at any point including mid-word or mid-packet:
  - State=IDLE; all counters and the assembly register cleared.
  - mem_we=0, mem_waddr=0, mem_wdata=0, done=0, err=0, busy=0.
  - rx_ready=1 from the first edge after release.
  - cpu_hold=HOLD_AT_RESET.
  - Partially loaded RAM contents are left as written.
- A new packet after done reasserts cpu_hold on acceptance of its SYNC_BYTE.

Test Plan:
- Reset, then A5 01 13 00 50 00: one mem_we at waddr 0 with wdata 0x00500013; done pulses in the same cycle; cpu_hold 1→0 on the next cycle; busy falls.
- A5 40 followed by 256 bytes, with rx_valid held continuously:
  - 64 writes at waddr 0..63.
  - rx_ready low exactly one cycle per word.
  - Word k data = {4k+3,4k+2,4k+1,4k} byte pattern.
  - done on the 64th write.
- Count errors:
  - A5 00 → err pulse, no mem_we, state back to IDLE.
  - A5 41 (N=65 with ADDR_W=6) → err pulse, no writes.
  - Then A5 01 + 4 bytes → normal load succeeds.
- Garbage then sync: bytes 00 FF 13 A5 02 + 8 bytes → the first three are discarded with no err; 2 words written at 0 and 1.
- Reset asserted after 2 bytes of word 3 of an N=5 load:
  - All outputs return to reset values immediately.
  - cpu_hold=1 with HOLD_AT_RESET=1.
  - A subsequent full N=5 load writes from address 0.
- Gapped rx_valid, and an A5 byte inside the data: random 0–7 idle cycles between bytes of A5 02 A5 A5 A5 A5 11 22 33 44 → wdata 0xA5A5A5A5 at waddr 0, then 0x44332211 at waddr 1; done pulses.
